// File: rtl/clock_divider_prog.sv
// clock_divider_prog
// Multi-channel programmable divider. Each channel divides clk by a runtime
// divisor D (1..2^CNT_W-1, 0 = channel off) and produces a registered
// divided-clock level plus a one-cycle tick in the last cycle of each period.
// The outputs are clock enables / timebase levels and are never used as
// real clocks.
//
// Divisor updates land only at a period boundary, so a period is never
// truncated or stretched. A sync pulse restarts every channel's phase
// together. A channel whose divisor is 0 takes a new divisor on every edge,
// so a load brings it back without waiting for a wrap.
//
// There are no handshakes: load, sync and en are plain per-edge strobes
// that are sampled on every rising edge of clk.

module clock_divider_prog #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       en,
  input  logic                    sync,
  input  logic [NUM_CH-1:0]       load,
  input  logic [NUM_CH*CNT_W-1:0] div_in,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH*CNT_W-1:0] div_active
);

  localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_shadow;
    logic [CNT_W-1:0] r_d;
    logic             r_clk_out;
    logic             r_tick;

    logic [CNT_W-1:0] w_div_slice;
    logic [CNT_W-1:0] w_nxt;
    logic [CNT_W-1:0] w_d_m1;
    logic [CNT_W-1:0] w_half;
    logic             w_off;
    logic             w_wrap;

    // Per-channel combinational helpers: next divisor, last count, high length.
    always_comb begin
      w_div_slice = div_in[g*CNT_W +: CNT_W];
      w_nxt       = load[g] ? w_div_slice : r_shadow;
      w_off       = (r_d == '0);
      // D=0 is never decremented; the off path does not use w_d_m1 anyway.
      w_d_m1      = w_off ? '0 : (r_d - ONE);
      // (D+1)>>1 without needing a CNT_W+1 bit adder.
      w_half      = (r_d >> 1) + {{(CNT_W-1){1'b0}}, r_d[0]};
      w_wrap      = (r_cnt == w_d_m1);
    end

    // Shadow divisor register: captures every load strobe.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_shadow <= RST_DIV;
      end else if (load[g]) begin
        r_shadow <= w_div_slice;
      end
    end

    // Divider core: sync, then off, then enabled count, else freeze.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_cnt     <= '0;
        r_clk_out <= 1'b0;
        r_tick    <= 1'b0;
        r_d       <= RST_DIV;
      end else if (sync) begin
        r_cnt     <= '0;
        r_clk_out <= 1'b0;
        r_tick    <= 1'b0;
        r_d       <= w_nxt;
      end else if (w_off) begin
        r_cnt     <= '0;
        r_clk_out <= 1'b0;
        r_tick    <= 1'b0;
        r_d       <= w_nxt;
      end else if (en[g]) begin
        r_clk_out <= (r_cnt < w_half);
        r_tick    <= w_wrap;
        if (w_wrap) begin
          r_cnt <= '0;
          r_d   <= w_nxt;
        end else begin
          r_cnt <= r_cnt + ONE;
        end
      end else begin
        r_tick <= 1'b0;
      end
    end

    assign clk_out[g]                   = r_clk_out;
    assign tick[g]                      = r_tick;
    assign div_active[g*CNT_W +: CNT_W] = r_d;
  end

endmodule

// File: tb/tb_clock_divider_prog.sv
// tb_clock_divider_prog
// Table-driven and randomized bench for clock_divider_prog (4 channels,
// 8-bit divisors, reset divisor 2). A period-position model predicts every
// output on every edge; directed sequences add hand-derived expectations.

module tb_clock_divider_prog;

  localparam int NUM_CH      = 4;
  localparam int CNT_W       = 8;
  localparam int DEFAULT_DIV = 2;
  localparam int W           = NUM_CH*CNT_W + 2*NUM_CH;

  logic                    clk;
  logic                    rst;
  logic [NUM_CH-1:0]       en;
  logic                    sync;
  logic [NUM_CH-1:0]       load;
  logic [NUM_CH*CNT_W-1:0] div_in;
  logic [NUM_CH-1:0]       clk_out;
  logic [NUM_CH-1:0]       tick;
  logic [NUM_CH*CNT_W-1:0] div_active;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q[$];

  // reference model: divisor in use, pending divisor, position in period
  int m_div  [NUM_CH];
  int m_pend [NUM_CH];
  int m_pos  [NUM_CH];
  bit m_clk  [NUM_CH];
  bit m_tick [NUM_CH];

  typedef struct {
    logic [3:0]  en;
    logic        sync;
    logic [3:0]  load;
    logic [31:0] div_in;
    logic [3:0]  exp_clk;
    logic [3:0]  exp_tick;
  } vec_t;

  vec_t tbl[17];

  clock_divider_prog #(
    .NUM_CH(NUM_CH),
    .CNT_W(CNT_W),
    .DEFAULT_DIV(DEFAULT_DIV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .sync(sync),
    .load(load),
    .div_in(div_in),
    .clk_out(clk_out),
    .tick(tick),
    .div_active(div_active)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_div[i]  = DEFAULT_DIV;
      m_pend[i] = DEFAULT_DIV;
      m_pos[i]  = 0;
      m_clk[i]  = 1'b0;
      m_tick[i] = 1'b0;
    end
  endtask

  // One rising edge of the model, using the inputs the DUT samples.
  task automatic model_edge();
    int sl, nxt, half;
    for (int i = 0; i < NUM_CH; i++) begin
      sl  = int'(div_in[i*CNT_W +: CNT_W]);
      nxt = load[i] ? sl : m_pend[i];
      if (load[i]) m_pend[i] = sl;
      if (sync || m_div[i] == 0) begin
        m_pos[i]  = 0;
        m_clk[i]  = 1'b0;
        m_tick[i] = 1'b0;
        m_div[i]  = nxt;
      end else if (en[i]) begin
        half      = (m_div[i] + 1) / 2;
        m_clk[i]  = (m_pos[i] < half);
        m_tick[i] = (m_pos[i] == m_div[i] - 1);
        m_pos[i]  = m_pos[i] + 1;
        if (m_pos[i] == m_div[i]) begin
          m_pos[i] = 0;
          m_div[i] = nxt;
        end
      end else begin
        m_tick[i] = 1'b0;
      end
    end
  endtask

  function automatic logic [W-1:0] model_vec();
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      v[i]                            = m_clk[i];
      v[NUM_CH+i]                     = m_tick[i];
      v[2*NUM_CH + i*CNT_W +: CNT_W]  = CNT_W'(m_div[i]);
    end
    return v;
  endfunction

  // Driver: one clock edge, then compare every output with the model.
  task automatic step();
    logic [W-1:0] exp_v;
    logic [W-1:0] act_v;
    @(posedge clk);
    model_edge();
    exp_q.push_back(model_vec());
    #1;
    act_v = {div_active, tick, clk_out};
    exp_v = exp_q.pop_front();
    check("model", 64'(act_v), 64'(exp_v));
  endtask

  task automatic drive(input logic [3:0] e, input logic s, input logic [3:0] l, input logic [31:0] d);
    en     = e;
    sync   = s;
    load   = l;
    div_in = d;
  endtask

  task automatic chk_ch(input string name, input int ch, input logic ec, input logic et);
    check({name, "_clk"}, 64'(clk_out[ch]), 64'(ec));
    check({name, "_tick"}, 64'(tick[ch]), 64'(et));
  endtask

  function automatic logic [7:0] div_of(input int ch);
    return div_active[ch*CNT_W +: CNT_W];
  endfunction

  task automatic async_reset_check(input string name);
    #3;
    rst = 1'b0;
    #1;
    model_reset();
    check({name, "_clk"}, 64'(clk_out), 64'(0));
    check({name, "_tick"}, 64'(tick), 64'(0));
    check({name, "_div"}, 64'(div_active), 64'({4{8'd2}}));
    #2;
    rst = 1'b1;
  endtask

  initial begin
    logic [3:0] exp_c;
    logic [3:0] exp_t;
    logic [7:0] d;

    // reset
    rst = 1'b0;
    drive(4'b0000, 1'b0, 4'b0000, 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_clk", 64'(clk_out), 64'(0));
    check("reset_tick", 64'(tick), 64'(0));
    check("reset_div", 64'(div_active), 64'({4{8'd2}}));
    rst = 1'b1;

    // default divide-by-2, then ch0 load 5 with sync
    for (int k = 1; k <= 6; k++)
      tbl[k-1] = '{4'b1111, 1'b0, 4'b0000, 32'h0,
                   (k % 2 == 1) ? 4'b1111 : 4'b0000,
                   (k % 2 == 0) ? 4'b1111 : 4'b0000};
    tbl[6]  = '{4'b1111, 1'b1, 4'b0001, 32'h0000_0005, 4'b0000, 4'b0000};
    tbl[7]  = '{4'b1111, 1'b0, 4'b0000, 32'h0, 4'b1111, 4'b0000};
    tbl[8]  = '{4'b1111, 1'b0, 4'b0000, 32'h0, 4'b0001, 4'b1110};
    tbl[9]  = '{4'b1111, 1'b0, 4'b0000, 32'h0, 4'b1111, 4'b0000};
    tbl[10] = '{4'b1111, 1'b0, 4'b0000, 32'h0, 4'b0000, 4'b1110};
    tbl[11] = '{4'b1111, 1'b0, 4'b0000, 32'h0, 4'b1110, 4'b0001};
    tbl[12] = '{4'b1111, 1'b0, 4'b0000, 32'h0, 4'b0001, 4'b1110};
    tbl[13] = '{4'b1111, 1'b0, 4'b0000, 32'h0, 4'b1111, 4'b0000};
    tbl[14] = '{4'b1111, 1'b0, 4'b0000, 32'h0, 4'b0001, 4'b1110};
    tbl[15] = '{4'b1111, 1'b0, 4'b0000, 32'h0, 4'b1110, 4'b0000};
    tbl[16] = '{4'b1111, 1'b0, 4'b0000, 32'h0, 4'b0000, 4'b1111};

    for (int v = 0; v < 17; v++) begin
      drive(tbl[v].en, tbl[v].sync, tbl[v].load, tbl[v].div_in);
      step();
      check($sformatf("tbl%0d_clk", v), 64'(clk_out), 64'(tbl[v].exp_clk));
      check($sformatf("tbl%0d_tick", v), 64'(tick), 64'(tbl[v].exp_tick));
    end
    check("t2_div0", 64'(div_of(0)), 64'(5));

    // ch1: D=4, reload to 6 while cnt=1
    drive(4'b1111, 1'b1, 4'b0010, 32'h0000_0400);
    step();
    check("t3_div_a", 64'(div_of(1)), 64'(4));
    drive(4'b1111, 1'b0, 4'b0000, 32'h0);
    step();
    chk_ch("t3_e1", 1, 1'b1, 1'b0);
    drive(4'b1111, 1'b0, 4'b0010, 32'h0000_0600);
    step();
    chk_ch("t3_e2", 1, 1'b1, 1'b0);
    check("t3_div_b", 64'(div_of(1)), 64'(4));
    drive(4'b1111, 1'b0, 4'b0000, 32'h0);
    step();
    chk_ch("t3_e3", 1, 1'b0, 1'b0);
    check("t3_div_c", 64'(div_of(1)), 64'(4));
    step();
    chk_ch("t3_e4", 1, 1'b0, 1'b1);
    check("t3_div_d", 64'(div_of(1)), 64'(6));
    for (int k = 0; k < 6; k++) begin
      step();
      chk_ch($sformatf("t3_p%0d", k), 1, (k < 3), (k == 5));
    end

    // ch2: switched off, then revived with D=1
    drive(4'b1111, 1'b1, 4'b0100, 32'h0);
    step();
    check("t4_div_off", 64'(div_of(2)), 64'(0));
    drive(4'b1111, 1'b0, 4'b0000, 32'h0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk_ch($sformatf("t4_off%0d", k), 2, 1'b0, 1'b0);
    end
    drive(4'b1111, 1'b0, 4'b0100, 32'h0001_0000);
    step();
    check("t4_div_on", 64'(div_of(2)), 64'(1));
    chk_ch("t4_rev", 2, 1'b0, 1'b0);
    drive(4'b1111, 1'b0, 4'b0000, 32'h0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk_ch($sformatf("t4_d1_%0d", k), 2, 1'b1, 1'b1);
    end

    // ch3: D=8, enable dropped for 7 cycles in the high phase
    drive(4'b1111, 1'b1, 4'b1000, 32'h0800_0000);
    step();
    drive(4'b1111, 1'b0, 4'b0000, 32'h0);
    for (int k = 0; k < 2; k++) begin
      step();
      chk_ch($sformatf("t5_run%0d", k), 3, 1'b1, 1'b0);
    end
    drive(4'b0111, 1'b0, 4'b0000, 32'h0);
    for (int k = 0; k < 7; k++) begin
      step();
      chk_ch($sformatf("t5_frz%0d", k), 3, 1'b1, 1'b0);
    end
    check("t5_div", 64'(div_of(3)), 64'(8));
    drive(4'b1111, 1'b0, 4'b0000, 32'h0);
    for (int k = 0; k < 7; k++) begin
      step();
      chk_ch($sformatf("t5_res%0d", k), 3, (k < 2 || k == 6), (k == 5));
    end

    // async reset mid-period, then restart at divide-by-2
    drive(4'b1111, 1'b0, 4'b0000, 32'h0);
    async_reset_check("t6_rst");
    for (int k = 1; k <= 4; k++) begin
      step();
      exp_c = (k % 2 == 1) ? 4'b1111 : 4'b0000;
      exp_t = (k % 2 == 0) ? 4'b1111 : 4'b0000;
      check($sformatf("t6_clk%0d", k), 64'(clk_out), 64'(exp_c));
      check($sformatf("t6_tick%0d", k), 64'(tick), 64'(exp_t));
    end

    // randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        en[i]   = ($urandom_range(0, 7) != 0);
        load[i] = ($urandom_range(0, 19) == 0);
        case ($urandom_range(0, 9))
          0:       d = 8'd0;
          1:       d = 8'd1;
          2:       d = 8'd255;
          3:       d = 8'd254;
          default: d = 8'($urandom_range(2, 12));
        endcase
        div_in[i*CNT_W +: CNT_W] = d;
      end
      sync = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 299) == 0) async_reset_check("rnd_rst");
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
